// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
// Holds the PC, presents it to instruction memory, and captures the returned
// word into the fetch register together with its address and address + 4.
// Optional performance counters (fetch_count, stall_count) are built only
// when the macro FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter int WIDTH = 22,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rd,
    output logic [WIDTH-1:0] instr_f,
    output logic [WIDTH-1:0] pc_f,
    output logic [WIDTH-1:0] pc_plus4_f,
    output logic             valid_f
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]      fetch_count,
    output logic [15:0]      stall_count
`endif
);

    // Word-aligned reset PC; the low two bits of the parameter are ignored.
    localparam logic [WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[WIDTH-1:2], 2'b00};
    localparam logic [WIDTH-1:0] PC_STEP          = WIDTH'(4);

    logic [WIDTH-1:0] pc_p0;
    logic [WIDTH-1:0] pc_plus4_p0;
    logic [WIDTH-1:0] target_aligned;
    logic             unused_target_lsbs;

    // Sequential PC increment; wraps modulo 2^WIDTH without any flag.
    assign pc_plus4_p0        = pc_p0 + PC_STEP;
    assign target_aligned     = {branch_target[WIDTH-1:2], 2'b00};
    assign unused_target_lsbs = ^branch_target[1:0];

    // The PC register feeds instruction memory directly.
    assign imem_addr = pc_p0;

    // PC and fetch register: reset > branch_taken > stall > flush > normal.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0      <= RESET_PC_ALIGNED;
            instr_f    <= '0;
            pc_f       <= '0;
            pc_plus4_f <= '0;
            valid_f    <= 1'b0;
        end else if (branch_taken) begin
            // Redirect wins over stall; the word fetched this cycle is dropped.
            pc_p0   <= target_aligned;
            instr_f <= '0;
            valid_f <= 1'b0;
        end else if (stall) begin
            // Hold everything; a concurrent flush only kills the held instruction.
            if (flush) begin
                instr_f <= '0;
                valid_f <= 1'b0;
            end
        end else if (flush) begin
            pc_p0   <= pc_plus4_p0;
            instr_f <= '0;
            valid_f <= 1'b0;
        end else begin
            // --- stage boundary: PC (p0) -> fetch register (f) ---
            pc_p0      <= pc_plus4_p0;
            instr_f    <= imem_rd;
            pc_f       <= pc_p0;
            pc_plus4_f <= pc_plus4_p0;
            valid_f    <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic fetch_event;
    logic stall_event;

    // A fetch event is exactly the case that loads valid_f with 1.
    assign fetch_event = !branch_taken && !stall && !flush;
    assign stall_event = !branch_taken && stall;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fetch_event) fetch_count <= sat_inc(fetch_count);
            if (stall_event) stall_count <= sat_inc(stall_count);
        end
    end
`endif

endmodule
